// File: rtl/hs_reg_slice.sv
// Valid/ready register slice: MODE selects pass-through, forward-registered,
// backward-registered (skid) or fully registered (2-entry) retiming.
module hs_reg_slice #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned MODE  = 2
) (
    input  logic             clk,
    input  logic             s_rst,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             src_ready,
    output logic             dst_valid,
    output logic [WIDTH-1:0] dst_data,
    input  logic             dst_ready,
    output logic [1:0]       occupancy
);

    if (MODE == 0) begin : g_pass
        // Pure wiring; only the reset gate on src_ready touches the handshake.
        assign src_ready = dst_ready & ~s_rst;
        assign dst_valid = src_valid;
        assign dst_data  = src_data;
        assign occupancy = 2'd0;

    end else if (MODE == 1) begin : g_fwd
        logic             r_out_valid;
        logic [WIDTH-1:0] r_out_data;
        logic             w_src_xfer;

        assign src_ready  = (~r_out_valid | dst_ready) & ~s_rst;
        assign w_src_xfer = src_valid & src_ready;

        // NOTE: state flops use non-blocking assignments so every flop samples
        // the pre-edge value of every other flop, independent of block order.
        always_ff @(posedge clk) begin
            if (s_rst) begin
                // NOTE: data flops are reset too, so dst_data reads 0 after
                // reset instead of leaking a discarded beat.
                r_out_valid <= 1'b0;
                r_out_data  <= '0;
            end else if (w_src_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= src_data;
            end else if (dst_ready) begin
                r_out_valid <= 1'b0;
            end
        end

        assign dst_valid = r_out_valid;
        assign dst_data  = r_out_data;
        assign occupancy = {1'b0, r_out_valid};

    end else if (MODE == 2) begin : g_skid
        logic             r_skid_valid;
        logic [WIDTH-1:0] r_skid_data;
        logic             w_src_xfer;

        assign src_ready  = ~r_skid_valid & ~s_rst;
        assign w_src_xfer = src_valid & src_ready;

        // A beat lands in the skid only when it is accepted but not consumed.
        always_ff @(posedge clk) begin
            if (s_rst) begin
                r_skid_valid <= 1'b0;
                r_skid_data  <= '0;
            end else if (r_skid_valid) begin
                if (dst_ready) r_skid_valid <= 1'b0;
            end else if (w_src_xfer && !dst_ready) begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= src_data;
            end
        end

        assign dst_valid = r_skid_valid | (src_valid & ~s_rst);
        assign dst_data  = r_skid_valid ? r_skid_data : src_data;
        assign occupancy = {1'b0, r_skid_valid};

    end else if (MODE == 3) begin : g_full
        logic [1:0]       r_count;
        logic [WIDTH-1:0] r_a;
        logic [WIDTH-1:0] r_b;
        logic             w_push;
        logic             w_pop;

        assign src_ready = (r_count != 2'd2) & ~s_rst;
        assign dst_valid = (r_count != 2'd0);
        assign dst_data  = r_a;
        assign occupancy = r_count;

        assign w_push = src_valid & src_ready;
        assign w_pop  = dst_valid & dst_ready;

        // Entry A always holds the head beat; B only fills when A is occupied.
        always_ff @(posedge clk) begin
            if (s_rst) begin
                r_count <= 2'd0;
                r_a     <= '0;
                r_b     <= '0;
            end else begin
                case ({w_push, w_pop})
                    2'b10: begin
                        if (r_count == 2'd0) r_a <= src_data;
                        else                 r_b <= src_data;
                        r_count <= r_count + 2'd1;
                    end
                    2'b01: begin
                        r_a     <= r_b;
                        r_count <= r_count - 2'd1;
                    end
                    2'b11: begin
                        if (r_count == 2'd2) begin
                            r_a <= r_b;
                            r_b <= src_data;
                        end else begin
                            r_a <= src_data;
                        end
                    end
                    default: ;
                endcase
            end
        end

    end else begin : g_bad_mode
        $error("hs_reg_slice: MODE must be 0..3");
        assign src_ready = 1'b0;
        assign dst_valid = 1'b0;
        assign dst_data  = '0;
        assign occupancy = 2'd0;
    end

endmodule

// File: tb/tb_hs_reg_slice.sv
// Directed and random checks of hs_reg_slice, one instance per MODE (0..3),
// each driven independently from a shared clock and reset.
module tb_hs_reg_slice;

    logic       clk = 1'b0;
    logic       s_rst;
    logic       src_valid [4];
    logic [7:0] src_data  [4];
    logic       src_ready [4];
    logic       dst_valid [4];
    logic [7:0] dst_data  [4];
    logic       dst_ready [4];
    logic [1:0] occupancy [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        hs_reg_slice #(.WIDTH(8), .MODE(g)) u_dut (
            .clk       (clk),
            .s_rst     (s_rst),
            .src_valid (src_valid[g]),
            .src_data  (src_data[g]),
            .src_ready (src_ready[g]),
            .dst_valid (dst_valid[g]),
            .dst_data  (dst_data[g]),
            .dst_ready (dst_ready[g]),
            .occupancy (occupancy[g])
        );
    end

    task automatic idle_all();
        for (int m = 0; m < 4; m++) begin
            src_valid[m] = 1'b0;
            src_data[m]  = 8'h00;
            dst_ready[m] = 1'b0;
        end
    endtask

    task automatic test_reset();
        s_rst = 1'b1;
        for (int m = 0; m < 4; m++) begin
            src_valid[m] = 1'b1;
            src_data[m]  = 8'h5A;
            dst_ready[m] = 1'b1;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        for (int m = 0; m < 4; m++) begin
            checks++;
            if (src_ready[m] !== 1'b0) begin
                errors++; $display("FAIL rst_src_ready mode=%0d got=%b exp=0", m, src_ready[m]);
            end
            checks++;
            if (occupancy[m] !== 2'd0) begin
                errors++; $display("FAIL rst_occupancy mode=%0d got=%0d exp=0", m, occupancy[m]);
            end
            if (m != 0) begin
                checks++;
                if (dst_valid[m] !== 1'b0) begin
                    errors++; $display("FAIL rst_dst_valid mode=%0d got=%b exp=0", m, dst_valid[m]);
                end
            end
        end
        s_rst = 1'b0;
        for (int m = 0; m < 4; m++) begin
            src_valid[m] = 1'b0;
            src_data[m]  = 8'h00;
        end
        #1;
        for (int m = 0; m < 4; m++) begin
            checks++;
            if (src_ready[m] !== 1'b1) begin
                errors++; $display("FAIL post_rst_src_ready mode=%0d got=%b exp=1", m, src_ready[m]);
            end
            checks++;
            if (dst_valid[m] !== 1'b0 || dst_data[m] !== 8'h00 || occupancy[m] !== 2'd0) begin
                errors++;
                $display("FAIL post_rst_outputs mode=%0d got valid=%b data=%h occ=%0d exp 0/00/0",
                         m, dst_valid[m], dst_data[m], occupancy[m]);
            end
        end
        idle_all();
    endtask

    task automatic test_back_to_back(input int m);
        int exp_v = 1;
        int first = -1;
        dst_ready[m] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            src_valid[m] = (c < 16);
            src_data[m]  = 8'(c + 1);
            #1;
            if (c < 16) begin
                checks++;
                if (src_ready[m] !== 1'b1) begin
                    errors++; $display("FAIL b2b_src_ready mode=%0d cyc=%0d got=%b exp=1", m, c, src_ready[m]);
                end
            end
            if (dst_valid[m] && dst_ready[m]) begin
                checks++;
                if (dst_data[m] !== 8'(exp_v)) begin
                    errors++; $display("FAIL b2b_data mode=%0d cyc=%0d got=%h exp=%h", m, c, dst_data[m], 8'(exp_v));
                end
                if (first < 0) first = c;
                exp_v++;
            end
            checks++;
            if (occupancy[m] > 2'd1) begin
                errors++; $display("FAIL b2b_occupancy mode=%0d cyc=%0d got=%0d exp<=1", m, c, occupancy[m]);
            end
        end
        checks++;
        if (exp_v != 17) begin
            errors++; $display("FAIL b2b_count mode=%0d got=%0d exp=16", m, exp_v - 1);
        end
        checks++;
        if (first != ((m == 1 || m == 3) ? 1 : 0)) begin
            errors++; $display("FAIL b2b_latency mode=%0d got=%0d exp=%0d", m, first, (m == 1 || m == 3) ? 1 : 0);
        end
        idle_all();
    endtask

    task automatic test_skid_mode2();
        // Per cycle: src data offered, dst_ready, expected src_ready/dst_valid/dst_data/occupancy.
        logic [7:0] v_data [6] = '{8'hA0, 8'hA1, 8'hA2, 8'hA2, 8'hA2, 8'h00};
        logic       v_sv   [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       v_dr   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic       e_sr   [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic       e_dv   [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] e_dd   [6] = '{8'hA0, 8'hA1, 8'hA1, 8'hA1, 8'hA2, 8'h00};
        logic [1:0] e_oc   [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0};
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            src_valid[2] = v_sv[c];
            src_data[2]  = v_data[c];
            dst_ready[2] = v_dr[c];
            #1;
            checks++;
            if (src_ready[2] !== e_sr[c] || dst_valid[2] !== e_dv[c] ||
                (e_dv[c] && dst_data[2] !== e_dd[c]) || occupancy[2] !== e_oc[c]) begin
                errors++;
                $display("FAIL skid cyc=%0d got sr=%b dv=%b dd=%h occ=%0d exp sr=%b dv=%b dd=%h occ=%0d",
                         c, src_ready[2], dst_valid[2], dst_data[2], occupancy[2],
                         e_sr[c], e_dv[c], e_dd[c], e_oc[c]);
            end
        end
        idle_all();
    endtask

    task automatic test_fill_mode3();
        logic [7:0] v_data [7] = '{8'h11, 8'h22, 8'h33, 8'h33, 8'h33, 8'h00, 8'h00};
        logic       v_sv   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       v_dr   [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic       e_sr   [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic       e_dv   [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] e_dd   [7] = '{8'h00, 8'h11, 8'h11, 8'h11, 8'h22, 8'h33, 8'h00};
        logic [1:0] e_oc   [7] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            src_valid[3] = v_sv[c];
            src_data[3]  = v_data[c];
            dst_ready[3] = v_dr[c];
            #1;
            checks++;
            if (src_ready[3] !== e_sr[c] || dst_valid[3] !== e_dv[c] ||
                (e_dv[c] && dst_data[3] !== e_dd[c]) || occupancy[3] !== e_oc[c]) begin
                errors++;
                $display("FAIL fill3 cyc=%0d got sr=%b dv=%b dd=%h occ=%0d exp sr=%b dv=%b dd=%h occ=%0d",
                         c, src_ready[3], dst_valid[3], dst_data[3], occupancy[3],
                         e_sr[c], e_dv[c], e_dd[c], e_oc[c]);
            end
        end
        idle_all();
    endtask

    task automatic test_reset_full_mode3();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            src_valid[3] = 1'b1;
            src_data[3]  = (c == 0) ? 8'h44 : 8'h55;
        end
        @(negedge clk);
        src_valid[3] = 1'b0;
        #1;
        checks++;
        if (occupancy[3] !== 2'd2 || src_ready[3] !== 1'b0) begin
            errors++; $display("FAIL rst3_prefill got occ=%0d sr=%b exp occ=2 sr=0", occupancy[3], src_ready[3]);
        end
        @(negedge clk);
        s_rst = 1'b1;
        #1;
        checks++;
        if (src_ready[3] !== 1'b0) begin
            errors++; $display("FAIL rst3_src_ready_in_reset got=%b exp=0", src_ready[3]);
        end
        @(negedge clk);
        s_rst = 1'b0;
        #1;
        checks++;
        if (dst_valid[3] !== 1'b0 || occupancy[3] !== 2'd0 || src_ready[3] !== 1'b1) begin
            errors++;
            $display("FAIL rst3_after got dv=%b occ=%0d sr=%b exp dv=0 occ=0 sr=1",
                     dst_valid[3], occupancy[3], src_ready[3]);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            dst_ready[3] = 1'b1;
            #1;
            checks++;
            if (dst_valid[3] !== 1'b0) begin
                errors++; $display("FAIL rst3_stale cyc=%0d got dv=%b exp=0", c, dst_valid[3]);
            end
        end
        idle_all();
    endtask

    task automatic test_random(input int m, input int n_beats);
        logic [7:0] q[$];
        int         sent = 0;
        int         got  = 0;
        int         cyc  = 0;
        logic       pend = 1'b0;
        logic [7:0] cur  = 8'h00;
        logic       prev_stall = 1'b0;
        logic [7:0] prev_data  = 8'h00;
        logic [7:0] exp_d;
        while (got < n_beats && cyc < 20000) begin
            @(negedge clk);
            if (!pend && sent < n_beats && $urandom_range(0, 1) == 1) begin
                pend = 1'b1;
                cur  = 8'($urandom);
            end
            src_valid[m] = pend;
            src_data[m]  = cur;
            dst_ready[m] = ($urandom_range(0, 1) == 1);
            #1;
            checks++;
            if (int'(occupancy[m]) != q.size()) begin
                errors++; $display("FAIL rand_occupancy mode=%0d cyc=%0d got=%0d exp=%0d", m, cyc, occupancy[m], q.size());
            end
            if (prev_stall) begin
                checks++;
                if (dst_valid[m] !== 1'b1 || dst_data[m] !== prev_data) begin
                    errors++;
                    $display("FAIL rand_stable mode=%0d cyc=%0d got dv=%b dd=%h exp dv=1 dd=%h",
                             m, cyc, dst_valid[m], dst_data[m], prev_data);
                end
            end
            if (src_valid[m] && src_ready[m]) begin
                q.push_back(cur);
                sent++;
                pend = 1'b0;
            end
            if (dst_valid[m] && dst_ready[m]) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_extra_beat mode=%0d cyc=%0d got=%h exp=none", m, cyc, dst_data[m]);
                end else begin
                    exp_d = q.pop_front();
                    if (dst_data[m] !== exp_d) begin
                        errors++; $display("FAIL rand_data mode=%0d cyc=%0d got=%h exp=%h", m, cyc, dst_data[m], exp_d);
                    end
                end
                got++;
            end
            prev_stall = dst_valid[m] & ~dst_ready[m];
            prev_data  = dst_data[m];
            cyc++;
        end
        checks++;
        if (got != n_beats) begin
            errors++; $display("FAIL rand_count mode=%0d got=%0d exp=%0d", m, got, n_beats);
        end
        idle_all();
    endtask

    initial begin
        idle_all();
        test_reset();
        for (int m = 0; m < 4; m++) test_back_to_back(m);
        test_skid_mode2();
        test_fill_mode3();
        test_reset_full_mode3();
        for (int m = 0; m < 4; m++) test_random(m, 1500);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
